// File: rtl/mult_input_ctrl.sv
// Push-button driven 4x4 unsigned shift-and-add multiplier: synchronises and
// debounces btn_go, then runs a four-state LOAD/CALC/DONE sequence per press.
module mult_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_go,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       prod_valid,
  output logic       busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             stable_q, stable_d, start_q, start_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  state_t           state_q, state_d;
  logic [7:0]       mcand_q, mcand_d, acc_q, acc_d, product_q, product_d;
  logic [3:0]       mplier_q, mplier_d;
  logic [1:0]       bcnt_q, bcnt_d;

  always_comb begin
    sync1_d  = btn_go;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    dcnt_d   = '0;
    // Counter only runs while the synchronised input disagrees with the stable level.
    if (sync2_q != stable_q) begin
      if (dcnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + CNT_W'(1);
      end
    end
    start_d = stable_d & ~stable_q;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    bcnt_d    = bcnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start_q) state_d = LOAD;
      end
      LOAD: begin
        mcand_d  = {4'b0000, a};
        mplier_d = b;
        acc_d    = 8'h00;
        bcnt_d   = 2'd0;
        state_d  = CALC;
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bcnt_d   = bcnt_q + 2'd1;
        // Product is captured on entry to DONE so it is already valid during DONE.
        if (bcnt_q == 2'd3) begin
          product_d = acc_d;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      start_q   <= 1'b0;
      dcnt_q    <= '0;
      state_q   <= IDLE;
      mcand_q   <= 8'h00;
      mplier_q  <= 4'h0;
      acc_q     <= 8'h00;
      bcnt_q    <= 2'd0;
      product_q <= 8'h00;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      start_q   <= start_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      bcnt_q    <= bcnt_d;
      product_q <= product_d;
    end
  end

  assign product    = product_q;
  assign prod_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mult_input_ctrl.sv
// Bench for mult_input_ctrl: per-cycle comparison against a behavioural model,
// a table of operand vectors, and hand-written press/glitch/reset sequences.
module tb_mult_input_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_go;
  logic [3:0] a_i, b_i;
  logic [7:0] product;
  logic       prod_valid, busy;

  mult_input_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn_go(btn_go), .a(a_i), .b(b_i),
    .product(product), .prod_valid(prod_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int vld_cnt = 0;
  int busy_cycles = 0;
  int last_prod = 0;

  // Model: history of sampled button levels, debounced level, and a phase
  // counter 0 (idle) .. 6 (result presented) for the operation in flight.
  logic       mh [0:DEB+1];
  logic       m_stable, m_strobe;
  int         m_ph;
  logic [7:0] m_cap, m_prod;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         hold;
    int         exp_prod;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= DEB + 1; j++) mh[j] = 1'b0;
    m_stable = 1'b0;
    m_strobe = 1'b0;
    m_ph     = 0;
    m_cap    = 8'h00;
    m_prod   = 8'h00;
  endtask

  task automatic model_edge();
    logic flip, new_strobe;
    if (rst) begin
      model_reset();
      return;
    end
    for (int j = DEB + 1; j >= 1; j--) mh[j] = mh[j-1];
    mh[0] = btn_go;
    // Level accepted once DEB consecutive synchronised samples disagree with it.
    flip = 1'b1;
    for (int j = 2; j <= DEB + 1; j++) if (mh[j] == m_stable) flip = 1'b0;
    new_strobe = flip && !m_stable;
    if (flip) m_stable = !m_stable;
    if (m_ph == 0) begin
      if (m_strobe) m_ph = 1;
    end else if (m_ph == 6) begin
      m_ph = 0;
    end else begin
      m_ph++;
      if (m_ph == 2) m_cap = 8'(a_i) * 8'(b_i);
      if (m_ph == 6) m_prod = m_cap;
    end
    m_strobe = new_strobe;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("product", int'(product), int'(m_prod));
    check("prod_valid", int'(prod_valid), int'(m_ph == 6));
    check("busy", int'(busy), int'(m_ph != 0));
    if (prod_valid === 1'b1) begin
      vld_cnt++;
      last_prod = int'(product);
    end
    if (busy === 1'b1) busy_cycles++;
  endtask

  task automatic press(input logic [3:0] av, input logic [3:0] bv, input int hold);
    a_i = av;
    b_i = bv;
    btn_go = 1'b1;
    repeat (hold) step();
    btn_go = 1'b0;
    repeat (16) step();
  endtask

  task automatic wait_busy(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(nm, int'(busy === 1'b1), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, bz0;
    rst = 1'b1;
    btn_go = 1'b0;
    a_i = 4'h0;
    b_i = 4'h0;
    model_reset();
    repeat (3) step();
    check("rst_product", int'(product), 0);
    rst = 1'b0;
    repeat (3) step();

    vecs.push_back('{4'd15, 4'd15, 10, 8'hE1});
    vecs.push_back('{4'd0,  4'd9,  10, 8'h00});
    vecs.push_back('{4'd3,  4'd5,  10, 8'h0F});
    vecs.push_back('{4'd7,  4'd7,  12, 8'h31});
    vecs.push_back('{4'd1,  4'd1,  10, 8'h01});
    vecs.push_back('{4'd15, 4'd0,  10, 8'h00});
    vecs.push_back('{4'd8,  4'd2,  10, 8'h10});
    vecs.push_back('{4'd12, 4'd13, 11, 8'h9C});
    foreach (vecs[i]) begin
      v0 = vld_cnt;
      bz0 = busy_cycles;
      press(vecs[i].a, vecs[i].b, vecs[i].hold);
      check("tbl_pulses", vld_cnt - v0, 1);
      check("tbl_product", last_prod, vecs[i].exp_prod);
      check("tbl_busy_len", busy_cycles - bz0, 6);
    end

    // Two-cycle glitch must not start anything.
    v0 = vld_cnt;
    bz0 = busy_cycles;
    btn_go = 1'b1;
    repeat (2) step();
    btn_go = 1'b0;
    repeat (15) step();
    check("glitch_pulses", vld_cnt - v0, 0);
    check("glitch_busy", busy_cycles - bz0, 0);
    check("glitch_product", int'(product), 8'h9C);

    // Button bounce and operand changes during CALC.
    v0 = vld_cnt;
    a_i = 4'd6;
    b_i = 4'd9;
    btn_go = 1'b1;
    wait_busy("calc_busy_seen");
    repeat (2) step();
    a_i = 4'd15;
    b_i = 4'd15;
    btn_go = 1'b0;
    step();
    btn_go = 1'b1;
    step();
    a_i = 4'd0;
    repeat (20) step();
    btn_go = 1'b0;
    repeat (16) step();
    check("calc_pulses", vld_cnt - v0, 1);
    check("calc_product", last_prod, 54);

    // Reset during CALC aborts with no pulse.
    v0 = vld_cnt;
    a_i = 4'd7;
    b_i = 4'd7;
    btn_go = 1'b1;
    wait_busy("rst_busy_seen");
    repeat (2) step();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_product", int'(product), 0);
    check("rst_async_valid", int'(prod_valid), 0);
    check("rst_async_busy", int'(busy), 0);
    btn_go = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (8) step();
    check("rst_abort_pulses", vld_cnt - v0, 0);
    press(4'd7, 4'd7, 10);
    check("rst_after_pulses", vld_cnt - v0, 1);
    check("rst_after_product", last_prod, 8'h31);

    // Long hold yields exactly one operation.
    v0 = vld_cnt;
    press(4'd9, 4'd12, 100);
    check("hold_pulses", vld_cnt - v0, 1);
    check("hold_product", last_prod, 108);

    // Button already high when reset releases.
    v0 = vld_cnt;
    rst = 1'b1;
    btn_go = 1'b1;
    a_i = 4'd11;
    b_i = 4'd3;
    #1;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();
    btn_go = 1'b0;
    repeat (16) step();
    check("rstheld_pulses", vld_cnt - v0, 1);
    check("rstheld_product", last_prod, 33);

    // Random operands and button patterns against the model.
    for (int i = 0; i < 300; i++) begin
      a_i = 4'($urandom_range(0, 15));
      b_i = 4'($urandom_range(0, 15));
      btn_go = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) step();
    end
    btn_go = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_input_ctrl.md
MULT_INPUT_CTRL -- requirements
Module: mult_input_ctrl

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 500000, consecutive stable clk cycles required to accept a new btn_go level.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port btn_go, input, 1 bit: raw, unsynchronised push-button start request.
REQ-005 The block SHALL have the port a, input, 4 bits: unsigned multiplicand from switches.
REQ-006 The block SHALL have the port b, input, 4 bits: unsigned multiplier from switches.
REQ-007 The block SHALL have the port product, output, 8 bits: registered a*b result, held until the next completed operation.
REQ-008 The block SHALL have the port prod_valid, output, 1 bit: one-cycle pulse marking a new product value, suitable as the display stage's load enable.
REQ-009 The block SHALL have the port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 btn_go SHALL pass through a two-flop synchroniser before any other use.
REQ-011 The debouncer SHALL hold a registered stable level; a counter SHALL increment while the synchronised input differs from the stable level and clear to 0 whenever they match.
REQ-012 The stable level SHALL take the synchronised value, and the counter SHALL clear, on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-013 Any pulse or glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the stable level.
REQ-014 A start event SHALL be a 0->1 transition of the stable level (one-cycle strobe); a 1->0 transition SHALL NOT start anything.
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, CALC, DONE.
REQ-016 In IDLE, a start strobe in cycle N SHALL move the FSM to LOAD for cycle N+1; otherwise the FSM SHALL stay in IDLE.
REQ-017 LOAD SHALL take 1 cycle and SHALL set multiplicand reg = {4'b0,a}, multiplier shift reg = b, accumulator = 0, and bit counter = 0.
REQ-018 CALC SHALL take exactly 4 cycles (N+2..N+5), one multiplier bit per cycle.
REQ-019 Each CALC cycle: if multiplier[0]=1, accumulator += multiplicand (8-bit, no overflow possible since 15*15=225); multiplicand <<= 1; multiplier >>= 1; counter++.
REQ-020 The FSM SHALL leave CALC for DONE after the 4th CALC cycle.
REQ-021 DONE SHALL take 1 cycle (N+6); during DONE, product SHALL equal the accumulator and prod_valid SHALL be 1; the next state SHALL be IDLE.
REQ-022 The total latency from the start strobe to prod_valid SHALL be 6 cycles.
REQ-023 prod_valid SHALL be 0 in every state other than DONE.
REQ-024 Changes on a or b after LOAD SHALL NOT affect the operation in progress.
REQ-025 A start strobe arriving while busy=1 SHALL be discarded, not queued; a start strobe in the same cycle DONE returns to IDLE SHALL also be discarded.
REQ-026 Holding btn_go high continuously SHALL produce exactly one operation; a new operation SHALL require a release and a re-press.
REQ-027 product SHALL change only in DONE or on reset.

Reset
REQ-028 While rst=1, independent of clk: state = IDLE, product = 8'h00, prod_valid = 0, busy = 0, synchroniser flops = 0, stable level = 0, debounce counter = 0, datapath registers = 0.
REQ-029 Asserting rst mid-operation SHALL abort the operation with no prod_valid pulse; after release the block SHALL wait in IDLE for a fresh press.
REQ-030 If btn_go is already high when rst deasserts, it SHALL be debounced and produce one start once it has been stable for DEBOUNCE_CYCLES cycles.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-031 a=15, b=15, clean press -> product=8'hE1 with a one-cycle prod_valid, 6 cycles after the start strobe; busy high for exactly 6 cycles.
REQ-032 a=0, b=9 press, then a=3, b=5 press -> product=8'h00, then 8'h0F; product holds between the pulses.
REQ-033 btn_go glitch 2 cycles wide -> no start, busy stays 0, product unchanged.
REQ-034 Second press and a/b changes during CALC -> no extra prod_valid, result equals the operands captured at LOAD.
REQ-035 rst pulsed during CALC (a=7, b=7) -> product=0, no prod_valid; a following press yields product=8'h31.
REQ-036 btn_go held high for 100 cycles -> exactly one prod_valid pulse.
